// File: rtl/cpu_pkg.sv
// Core-wide widths and the result packet carried on the common data bus.
// The FU, ROB, IQ and LSQ share these definitions.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int IDX_W  = 6;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  rob_index;
    } cdb_pkt_t;

    // Index width for an n-entry pointer, never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_select.sv
// Round-robin multi-grant selector: grants the first NUM_LANES candidates from rr_ptr.
// Purely combinational so it can also serve as an issue-select picker.
module cdb_rr_select
    import cpu_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_LANES = 3,
    parameter int PTR_W     = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                cand,
    input  logic [PTR_W-1:0]                  rr_ptr,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_LANES-1:0]              lane_valid,
    output logic [NUM_LANES-1:0][PTR_W-1:0]   lane_idx,
    output logic [PTR_W-1:0]                  next_ptr
);

    always_comb begin
        int  n_grant;
        int  pos;
        logic spill;

        grant      = '0;
        lane_valid = '0;
        lane_idx   = '0;
        next_ptr   = rr_ptr;
        n_grant    = 0;
        pos        = 0;
        spill      = 1'b0;

        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == pos && cand[j]) begin
                    if (n_grant < NUM_LANES) begin
                        grant[j] = 1'b1;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (l == n_grant) begin
                                lane_valid[l] = 1'b1;
                                lane_idx[l]   = PTR_W'(j);
                            end
                        end
                        n_grant = n_grant + 1;
                    end else if (!spill) begin
                        // First loser becomes top priority next cycle.
                        spill    = 1'b1;
                        next_ptr = PTR_W'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB lane arbiter: accepts one result per producer, holds losers for one retry,
// and broadcasts up to NUM_LANES granted results on registered lanes.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_LANES = 3,
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int TAG_W     = cpu_pkg::TAG_W,
    parameter int IDX_W     = cpu_pkg::IDX_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]      req_rob_index,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_LANES-1:0]               cdb_valid,
    output logic [NUM_LANES-1:0][DATA_W-1:0]   cdb_data,
    output logic [NUM_LANES-1:0][TAG_W-1:0]    cdb_tags,
    output logic [NUM_LANES-1:0][IDX_W-1:0]    cdb_rob_index
);

    localparam int PTR_W = cpu_pkg::ptr_w(NUM_REQ);

    typedef cpu_pkg::cdb_pkt_t pkt_t;

    logic [NUM_REQ-1:0]               hold_valid;
    pkt_t [NUM_REQ-1:0]               hold_pkt;
    logic [NUM_REQ-1:0]               accept;
    logic [NUM_REQ-1:0]               cand;
    logic [NUM_REQ-1:0]               grant;
    pkt_t [NUM_REQ-1:0]               in_pkt;
    pkt_t [NUM_REQ-1:0]               cand_pkt;
    logic [PTR_W-1:0]                 rr_ptr;
    logic [PTR_W-1:0]                 next_ptr;
    logic [NUM_LANES-1:0]             lane_valid;
    logic [NUM_LANES-1:0][PTR_W-1:0]  lane_idx;
    logic [NUM_LANES-1:0]             lane_valid_q;
    pkt_t [NUM_LANES-1:0]             lane_q;

    // Ready depends only on state, so producers never see a loop through valid.
    assign req_ready = ~hold_valid & {NUM_REQ{~rst}};
    assign accept    = req_valid & req_ready;
    assign cand      = hold_valid | accept;

    always_comb begin
        in_pkt   = '0;
        cand_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_pkt[i].data      = req_data[i];
            in_pkt[i].tag       = req_tag[i];
            in_pkt[i].rob_index = req_rob_index[i];
            cand_pkt[i]         = hold_valid[i] ? hold_pkt[i] : in_pkt[i];
        end
    end

    cdb_rr_select #(
        .NUM_REQ   (NUM_REQ),
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_select (
        .cand       (cand),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .lane_valid (lane_valid),
        .lane_idx   (lane_idx),
        .next_ptr   (next_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid   <= '0;
            hold_pkt     <= '0;
            rr_ptr       <= '0;
            lane_valid_q <= '0;
            lane_q       <= '0;
        end else begin
            rr_ptr       <= next_ptr;
            lane_valid_q <= lane_valid;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end else if (accept[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_pkt[i]   <= in_pkt[i];
                end
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                lane_q[l] <= lane_valid[l] ? cand_pkt[lane_idx[l]] : '0;
            end
        end
    end

    assign cdb_valid = lane_valid_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign cdb_data[l]      = lane_q[l].data;
        assign cdb_tags[l]      = lane_q[l].tag;
        assign cdb_rob_index[l] = lane_q[l].rob_index;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table with a lane scoreboard,
// then a saturation run checking per-producer order, lane fill and grant balance.
module tb_cdb_arbiter;
    import cpu_pkg::*;

    localparam int NR = 4;
    localparam int NL = 3;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NR-1:0]                 req_valid = '0;
    logic [NR-1:0][DATA_W-1:0]     req_data = '0;
    logic [NR-1:0][TAG_W-1:0]      req_tag = '0;
    logic [NR-1:0][IDX_W-1:0]      req_rob_index = '0;
    logic [NR-1:0]                 req_ready;
    logic [NL-1:0]                 cdb_valid;
    logic [NL-1:0][DATA_W-1:0]     cdb_data;
    logic [NL-1:0][TAG_W-1:0]      cdb_tags;
    logic [NL-1:0][IDX_W-1:0]      cdb_rob_index;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_REQ   (NR),
        .NUM_LANES (NL),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .req_rob_index (req_rob_index),
        .req_ready     (req_ready),
        .cdb_valid     (cdb_valid),
        .cdb_data      (cdb_data),
        .cdb_tags      (cdb_tags),
        .cdb_rob_index (cdb_rob_index)
    );

    typedef struct packed {
        logic                 rst;
        logic [NR-1:0]        valid;
        cdb_pkt_t [NR-1:0]    in_p;
        logic [NR-1:0]        ready;
        logic [NL-1:0]        cvalid;
        cdb_pkt_t [NL-1:0]    out_p;
    } vec_t;

    typedef struct packed {
        logic [NL-1:0]        cvalid;
        cdb_pkt_t [NL-1:0]    out_p;
    } exp_t;

    typedef struct packed {
        logic [1:0]           r;
        logic [DATA_W-1:0]    d;
        logic [IDX_W-1:0]     x;
    } sat_t;

    vec_t tbl[$];
    exp_t sb[$];
    sat_t mq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Payload of requester i in stimulus group g.
    function automatic cdb_pkt_t P(input logic [7:0] g, input int i);
        cdb_pkt_t p;
        p.data      = {g, 24'(i)};
        p.tag       = TAG_W'(int'(g) + i);
        p.rob_index = IDX_W'(int'(g) * 2 + i);
        return p;
    endfunction

    task automatic add(input logic r, input logic [NR-1:0] v, input logic [7:0] g,
                       input logic [NR-1:0] rdy, input logic [NL-1:0] cv,
                       input cdb_pkt_t l0, input cdb_pkt_t l1, input cdb_pkt_t l2);
        vec_t t;
        t.rst   = r;
        t.valid = v;
        for (int i = 0; i < NR; i++) t.in_p[i] = P(g, i);
        t.ready    = rdy;
        t.cvalid   = cv;
        t.out_p[0] = l0;
        t.out_p[1] = l1;
        t.out_p[2] = l2;
        tbl.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cdb_pkt_t db;
        vec_t     t;
        exp_t     e;
        int       seq[NR];
        int       grants[NR];
        logic [NR-1:0] prev_low;
        int       nv;
        int       hit;
        int       want;

        db.data = 32'hDEADBEEF;
        db.tag = 6'd5;
        db.rob_index = 6'd9;

        //  rst valid    grp    ready    cvalid  lane0          lane1          lane2
        add(1, 4'b1111, 8'h55, 4'b0000, 3'b000, '0,            '0,            '0);
        add(1, 4'b1111, 8'h55, 4'b0000, 3'b000, '0,            '0,            '0);
        add(0, 4'b0000, 8'h55, 4'b1111, 3'b000, '0,            '0,            '0);
        add(0, 4'b0100, 8'h55, 4'b1111, 3'b001, db,            '0,            '0);
        tbl[tbl.size()-1].in_p[2] = db;
        add(0, 4'b0000, 8'h55, 4'b1111, 3'b000, '0,            '0,            '0);
        add(0, 4'b1111, 8'h0A, 4'b1111, 3'b111, P(8'h0A, 0),   P(8'h0A, 1),   P(8'h0A, 2));
        add(0, 4'b1111, 8'h0B, 4'b0111, 3'b111, P(8'h0A, 3),   P(8'h0B, 0),   P(8'h0B, 1));
        add(0, 4'b0000, 8'h55, 4'b1011, 3'b001, P(8'h0B, 2),   '0,            '0);
        add(0, 4'b0000, 8'h55, 4'b1111, 3'b000, '0,            '0,            '0);
        add(0, 4'b1111, 8'h0C, 4'b1111, 3'b111, P(8'h0C, 2),   P(8'h0C, 3),   P(8'h0C, 0));
        add(1, 4'b1111, 8'h0D, 4'b0000, 3'b000, '0,            '0,            '0);
        add(0, 4'b0000, 8'h55, 4'b1111, 3'b000, '0,            '0,            '0);
        add(0, 4'b1111, 8'h0E, 4'b1111, 3'b111, P(8'h0E, 0),   P(8'h0E, 1),   P(8'h0E, 2));
        add(0, 4'b0000, 8'h55, 4'b0111, 3'b001, P(8'h0E, 3),   '0,            '0);
        add(0, 4'b0000, 8'h55, 4'b1111, 3'b000, '0,            '0,            '0);
        add(0, 4'b1010, 8'h0F, 4'b1111, 3'b011, P(8'h0F, 3),   P(8'h0F, 1),   '0);
        add(0, 4'b0000, 8'h55, 4'b1111, 3'b000, '0,            '0,            '0);

        for (int k = 0; k < tbl.size(); k++) begin
            t = tbl[k];
            rst       = t.rst;
            req_valid = t.valid;
            for (int i = 0; i < NR; i++) begin
                req_data[i]      = t.in_p[i].data;
                req_tag[i]       = t.in_p[i].tag;
                req_rob_index[i] = t.in_p[i].rob_index;
            end
            @(negedge clk);
            check("vec_req_ready", 64'(req_ready), 64'(t.ready));
            e.cvalid = t.cvalid;
            e.out_p  = t.out_p;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("vec_cdb_valid", 64'(cdb_valid), 64'(e.cvalid));
            for (int l = 0; l < NL; l++) begin
                check("vec_cdb_data", 64'(cdb_data[l]), 64'(e.out_p[l].data));
                check("vec_cdb_tag", 64'(cdb_tags[l]), 64'(e.out_p[l].tag));
                check("vec_cdb_rob_index", 64'(cdb_rob_index[l]), 64'(e.out_p[l].rob_index));
            end
        end

        // Saturation: every producer offers back-to-back results for 12 cycles.
        rst = 1'b1;
        req_valid = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        prev_low = '0;
        for (int i = 0; i < NR; i++) begin
            seq[i] = 0;
            grants[i] = 0;
        end
        for (int c = 0; c < 14; c++) begin
            req_valid = (c < 12) ? '1 : '0;
            for (int i = 0; i < NR; i++) begin
                req_data[i]      = {8'(i), 24'(seq[i])};
                req_tag[i]       = TAG_W'(i);
                req_rob_index[i] = IDX_W'(seq[i]);
            end
            @(negedge clk);
            check("sat_hold_age", 64'(prev_low & ~req_ready), 64'(0));
            prev_low = ~req_ready;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mq.push_back('{r: 2'(i), d: req_data[i], x: req_rob_index[i]});
                    seq[i]++;
                end
            end
            @(posedge clk);
            #1;
            nv = 0;
            for (int l = 0; l < NL; l++) begin
                if (cdb_valid[l]) begin
                    nv++;
                    hit = -1;
                    for (int q = 0; q < mq.size(); q++) begin
                        if (hit < 0 && TAG_W'(mq[q].r) == cdb_tags[l]) hit = q;
                    end
                    if (hit < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sat_unexpected: got tag 0x%0h data 0x%0h, expected a pending result",
                                 cdb_tags[l], cdb_data[l]);
                    end else begin
                        check("sat_order_data", 64'(cdb_data[l]), 64'(mq[hit].d));
                        check("sat_order_rob_index", 64'(cdb_rob_index[l]), 64'(mq[hit].x));
                        grants[int'(mq[hit].r)]++;
                        mq.delete(hit);
                    end
                end
            end
            want = (c < 12) ? 3 : ((c == 12) ? 1 : 0);
            check("sat_lane_count", 64'(nv), 64'(want));
        end
        check("sat_pending_left", 64'(mq.size()), 64'(0));
        for (int i = 0; i < NR; i++) begin
            check("sat_grant_balance", 64'((grants[i] >= 8 && grants[i] <= 10) ? 1 : 0), 64'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the common data bus lanes between result producers in the out-of-order core: the functional units and the LSU load-return port. Up to NUM_REQ producers offer one result each per cycle. The block grants up to NUM_LANES of them round-robin and drives the granted results onto registered CDB lanes consumed by the ROB, issue queue and load/store queue. A producer that loses arbitration keeps its result in a one-entry hold register and sees ready deasserted until that result is broadcast.

## Interface
Parameters:
- NUM_REQ, 4: number of producers (3 FUs + LSU load).
- NUM_LANES, 3: number of CDB lanes; 1 ≤ NUM_LANES ≤ NUM_REQ.
- DATA_W, 32: result width.
- TAG_W, 6: physical tag width.
- IDX_W, 6: ROB index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [NUM_REQ]  producer i offers a result.
- req_data  in  [NUM_REQ] x DATA_W  result value.
- req_tag  in  [NUM_REQ] x TAG_W  destination physical tag.
- req_rob_index  in  [NUM_REQ] x IDX_W  ROB entry of the result.
- req_ready  out  [NUM_REQ]  producer i may present a new result this cycle.
- cdb_valid  out  [NUM_LANES]  lane broadcast valid.
- cdb_data  out  [NUM_LANES] x DATA_W  broadcast value.
- cdb_tags  out  [NUM_LANES] x TAG_W  broadcast tag.
- cdb_rob_index  out  [NUM_LANES] x IDX_W  broadcast ROB index.

## Operation
- State:
  - per-requester hold register (valid, data, tag, rob_index);
  - rr_ptr, width clog2(NUM_REQ), the highest-priority requester;
  - registered CDB lane outputs.
- req_ready[i] = ~rst & ~hold_valid[i]. It is combinational from state only, with no dependence on req_valid.
- Acceptance: the result is accepted when req_valid[i] & req_ready[i]. When req_ready[i] = 0, req_valid[i] and its payload are ignored.
- Candidate i:
  - the hold register if hold_valid[i];
  - otherwise the accepted input.
  - At most one candidate per requester.
- Selection: scan requesters in order rr_ptr, rr_ptr+1, … (mod NUM_REQ). The first NUM_LANES candidates are granted. The k-th grant drives lane k, so lanes fill from lane 0 upward.
- Ungranted candidate:
  - an accepted input is written into the hold register;
  - an existing hold entry stays.
- Granted hold entry: cleared.
- rr_ptr update:
  - if any candidate went ungranted, rr_ptr ← the first ungranted requester in scan order;
  - otherwise rr_ptr is unchanged.
- No reordering within a requester. Results from one producer reach the CDB in acceptance order.
- Payload is never modified. Lanes with no grant drive cdb_valid = 0, with data, tag and index fields forced to 0.

## Timing
- Reset values:
  - cdb_valid = 0, cdb_data/tags/rob_index = 0;
  - all hold_valid = 0, rr_ptr = 0;
  - req_ready = 0 while rst is high, all 1 on the first cycle after.
- Latency: a result granted in cycle N (accepted or held) appears on its lane in cycle N+1, for exactly one cycle.
- Throughput: NUM_LANES results per cycle sustained.
- Fairness:
  - a held result is granted within ceil(NUM_REQ/NUM_LANES) − 1 cycles after being held;
  - for the defaults, it is granted the very next cycle.
- No contention (candidates ≤ NUM_LANES): every candidate is granted, nothing is held, and req_ready stays 1.
- Reset mid-operation:
  - held results are discarded;
  - the cdb lanes read 0/invalid on the cycle after rst is sampled high.
- Rename and ROB recovery on lost results is not this block's concern. Reset is a full pipeline reset.
- No combinational path from req_* to cdb_*. req_* feeds cdb_* only through registers.

## Structure
- Shared package cpu_pkg:
  - DATA_W, TAG_W and IDX_W constants, shared with the FU, ROB, IQ and LSQ;
  - a cdb_pkt_t struct {data, tag, rob_index} used for hold registers and lanes.
- Sub-module cdb_rr_select, purely combinational:
  - inputs: candidate vector and rr_ptr;
  - outputs: grant vector, per-lane requester index plus lane valid, and next rr_ptr.
  - It is reusable for IQ issue select.
- Top level holds registers, acceptance logic and lane muxing.

## Test plan
- Reset: hold rst 2 cycles with req_valid = 4'b1111 → cdb_valid = 0 and req_ready = 0 throughout. On the first cycle after, req_ready = 4'b1111.
- Single producer: req 2 offers data 0xDEADBEEF, tag 5, rob_index 9 in cycle N → in cycle N+1, lane 0 carries those values with cdb_valid = 3'b001. Nothing is held.
- Contention at rr_ptr = 0: all 4 valid in cycle N (payloads A0..A3) → lanes at N+1 = A0, A1, A2. A3 is held, req_ready[3] = 0 in N+1, and rr_ptr = 3.
- Continue from the contention case: in N+1, reqs 0–2 offer B0..B2 → lanes at N+2 = A3, B0, B1. B2 is held, rr_ptr = 2, and per-producer order is preserved.
- Saturation: all 4 valid every cycle for 12 cycles → 3 valid lanes per cycle from cycle 2. Each requester receives 9 grants ±1, and no hold persists more than 1 cycle.
- Reset mid-hold: rst asserted the cycle after A3 is held → A3 is never broadcast, cdb_valid = 0 next cycle, and req_ready = 4'b1111 after rst drops.
